debouncer_multi: RTL

- Parametrised N-channel push-button conditioner. Successor to the single-channel debouncer.
- Per channel it provides:
  - a synchroniser of configurable depth
  - selectable input polarity
  - a debounce window of configurable length
  - registered press and release pulses
  - long-press detection
- Sits between raw board buttons and the control FSMs. All channels are independent and share one clock.

---
 rtl/debouncer_multi.sv | 114 +++++++++++
 1 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel button conditioner (sync, debounce, press/release/long pulses).
// Define DEBOUNCER_AUTOREPEAT_EN to add per-channel auto-repeat pulses.
module debouncer_multi #(
   parameter int CHANNELS     = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int ACTIVE_LOW   = 1,
   parameter int HOLD_SHIFT   = 6,
   parameter int REPEAT_WIDTH = 20
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CHANNELS-1:0] PUSH_BUTTON,
   output logic [CHANNELS-1:0] PUSH_BUTTON_STATE,
   output logic [CHANNELS-1:0] PUSH_BUTTON_DOWN,
   output logic [CHANNELS-1:0] PUSH_BUTTON_UP,
   output logic [CHANNELS-1:0] PUSH_BUTTON_LONG,
   output logic [CHANNELS-1:0] PUSH_BUTTON_REPEAT
);

   localparam int HW = CNT_WIDTH + HOLD_SHIFT;

   logic [CHANNELS-1:0] w_raw;

   assign w_raw = (ACTIVE_LOW != 0) ? ~PUSH_BUTTON : PUSH_BUTTON;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_WIDTH-1:0]   r_cnt;
      logic [HW-1:0]          r_hold;
      logic                   r_state;
      logic                   r_down;
      logic                   r_up;
      logic                   r_long;
      logic                   r_fired;
      logic                   w_diff;
      logic                   w_toggle;
      logic                   w_hold_clr;
      logic                   w_long_hit;

      assign w_diff     = r_sync[SYNC_STAGES-1] ^ r_state;
      assign w_toggle   = w_diff & (&r_cnt);
      // HOLD tracks the next STATE, so it is already 0 on the release edge
      assign w_hold_clr = ~r_state | w_toggle;
      assign w_long_hit = ~w_hold_clr & (&r_hold) & ~r_fired;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_state <= 1'b0;
            r_down  <= 1'b0;
            r_up    <= 1'b0;
            r_long  <= 1'b0;
            r_fired <= 1'b0;
         end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
            r_state <= r_state ^ w_toggle;
            r_down  <= w_toggle & ~r_state;
            r_up    <= w_toggle & r_state;
            r_long  <= w_long_hit;

            if (!w_diff || w_toggle)
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + 1'b1;

            if (w_hold_clr) begin
               r_hold  <= '0;
               r_fired <= 1'b0;
            end else begin
               if (!(&r_hold))
                  r_hold <= r_hold + 1'b1;
               if (w_long_hit)
                  r_fired <= 1'b1;
            end
         end
      end

      assign PUSH_BUTTON_STATE[g] = r_state;
      assign PUSH_BUTTON_DOWN[g]  = r_down;
      assign PUSH_BUTTON_UP[g]    = r_up;
      assign PUSH_BUTTON_LONG[g]  = r_long;

`ifdef DEBOUNCER_AUTOREPEAT_EN
      logic [REPEAT_WIDTH-1:0] r_rpt;
      logic                    r_rep;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_rpt <= '0;
            r_rep <= 1'b0;
         end else if (w_hold_clr) begin
            r_rpt <= '0;
            r_rep <= 1'b0;
         end else if (w_long_hit) begin
            r_rpt <= '0;
            r_rep <= 1'b1;
         end else if (r_fired) begin
            r_rpt <= r_rpt + 1'b1;
            r_rep <= &r_rpt;
         end else begin
            r_rep <= 1'b0;
         end
      end

      assign PUSH_BUTTON_REPEAT[g] = r_rep;
`else
      assign PUSH_BUTTON_REPEAT[g] = (REPEAT_WIDTH < 1);
`endif
   end

endmodule
